side_buffer: RTL
================

SIDE_BUFFER -- requirements
Module: side_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the flit width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, giving the number of cycles a head flit may wait before forced reinjection is requested.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 wr_en  input  1  deflected flit presented for buffering this cycle.
REQ-007 wr_data  input  WIDTH  flit to buffer.
REQ-008 rd_req  input  1  reinjection slot available this cycle; pops the head when rd_valid=1.
REQ-009 rd_valid  output  1  head flit present, equal to ~empty.
REQ-010 rd_data  output  WIDTH  head flit when rd_valid=1, all-zero otherwise.
REQ-011 full  output  1  count==DEPTH.
REQ-012 empty  output  1  count==0.
REQ-013 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-014 force_inject  output  1  the head has starved; the router must grant a slot.
REQ-015 overflow  output  1  sticky; a write was dropped.

Function
REQ-016 Push SHALL occur when wr_en=1 and (full=0 or pop occurs in the same cycle); the flit is written at the write pointer, which then increments modulo DEPTH.
REQ-017 Pop SHALL occur when rd_req=1 and empty=0; the read pointer then increments modulo DEPTH.
REQ-018 There SHALL be no write-to-read bypass: a pushed flit SHALL become visible on rd_data no earlier than the cycle after the push.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-020 Push into an empty buffer with rd_req=1 in the same cycle SHALL push only; pop is ignored.
REQ-021 wr_en=1 when full and no pop occurs SHALL drop the flit, leave all state unchanged except overflow, and set overflow=1 until reset.
REQ-022 rd_req=1 when empty SHALL have no effect.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 without a gap or a duplicate entry.
REQ-024 A starvation counter SHALL be cleared on every pop and whenever empty=1.
REQ-025 The starvation counter SHALL increment each cycle the buffer is non-empty and no pop occurs, and SHALL saturate at STARVE_LIMIT.
REQ-026 force_inject SHALL be registered and SHALL equal 1 exactly when the starvation counter equals STARVE_LIMIT.
REQ-027 force_inject SHALL fall to 0 in the cycle after the pop of the starving head.
REQ-028 count, full and empty SHALL be mutually consistent in every cycle.

Reset
REQ-029 On reset=0, pointers, count, starvation counter, force_inject and overflow SHALL clear to 0 asynchronously.
REQ-030 During and after reset, empty=1, full=0, rd_valid=0 and rd_data=0.
REQ-031 Storage contents need not be reset; they SHALL never appear on rd_data while empty=1.
REQ-032 Reset asserted mid-operation SHALL discard all buffered flits; the first push after release SHALL be the head.

Structure
REQ-033 Parameter defaults and the pointer and count width helpers SHALL live in the shared router package.
REQ-034 The starvation counter and the force_inject register SHALL form one sub-module, side_buffer_starve_ctr, with inputs nonempty, pop and limit and output force.
REQ-035 Storage SHALL be a register array with no reset; all other state SHALL use the asynchronous active-low reset.

Verification
REQ-036 After reset, push A, B, C, D on consecutive cycles with no pops -> full=1 and count=4; rd_data=A one cycle after A's push.
REQ-037 When full, push E with no pop -> overflow=1 sticky, count=4 and E is lost; four pops then return A, B, C, D.
REQ-038 When full, push and pop in the same cycle -> count stays 4, A is popped and E becomes the tail; repeat for 8 cycles and confirm pointer wrap with in-order data.
REQ-039 When empty, wr_en=1 and rd_req=1 together -> count=1 and rd_valid=1 next cycle; no spurious pop occurs.
REQ-040 One flit held with rd_req=0 for 8 cycles -> force_inject=1 after the 8th stalled cycle; pop it -> force_inject=0 on the next cycle.
REQ-041 Assert reset with 3 entries buffered -> empty=1, rd_data=0 and force_inject=0 immediately; after release, push X -> rd_data=X.

Source files
------------

// File: rtl/side_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : side_buffer_pkg
// Purpose  : Shared defaults and width helpers for the deflection side buffer.
// Revision : 1.0 - initial release
// ============================================================================
package side_buffer_pkg;

    localparam int c_DEF_WIDTH        = 64;
    localparam int c_DEF_DEPTH        = 4;
    localparam int c_DEF_STARVE_LIMIT = 8;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so that count can represent DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int starve_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/side_buffer_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : side_buffer_starve_ctr
// Purpose  : Saturating head-starvation counter with registered force flag.
// Revision : 1.0 - initial release
// ============================================================================
module side_buffer_starve_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nonempty,
    input  logic             pop,
    input  logic [CNT_W-1:0] limit,
    output logic             force_inject
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_force;

    always_comb begin
        w_cnt_next = r_cnt;
        if (!nonempty || pop) begin
            w_cnt_next = '0;
        end else if (r_cnt != limit) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // The flag is registered from the next count so it tracks r_cnt == limit exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_force <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_force <= (w_cnt_next == limit);
        end
    end

    assign force_inject = r_force;

endmodule
`default_nettype wire

// File: rtl/side_buffer.sv
`default_nettype none
// ============================================================================
// Module   : side_buffer
// Purpose  : Small FIFO holding deflected flits until a reinjection slot opens.
// Revision : 1.0 - initial release
// ============================================================================
module side_buffer
    import side_buffer_pkg::*;
#(
    parameter int WIDTH        = c_DEF_WIDTH,
    parameter int DEPTH        = c_DEF_DEPTH,
    parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          force_inject,
    output logic                          overflow
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_CNT_W = count_width(DEPTH);
    localparam int c_STV_W = starve_width(STARVE_LIMIT);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_pop   = rd_req & ~w_empty;
    // A pop frees the slot in the same cycle, so a full buffer still accepts.
    assign w_push  = wr_en & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; the empty gate below keeps stale data hidden.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    side_buffer_starve_ctr #(
        .CNT_W (c_STV_W)
    ) u_starve_ctr (
        .clk          (clk),
        .reset        (reset),
        .nonempty     (~w_empty),
        .pop          (w_pop),
        .limit        (c_STV_W'(STARVE_LIMIT)),
        .force_inject (force_inject)
    );

    assign rd_valid = ~w_empty;
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
